// File: rtl/verinject_memn_injector.sv
// Multi-port memory fault injector: XORs stored and live bit flips into read data, remembering faults
// in a circular buffer until their word is rewritten. Optional statistics via VERINJECT_MEM_STATS_EN.
module verinject_memn_injector #(
  parameter int          LEFT       = 0,
  parameter int          RIGHT      = 0,
  parameter int          ADDR_LEFT  = 0,
  parameter int          ADDR_RIGHT = 0,
  parameter int          MEM_LEFT   = 0,
  parameter int          MEM_RIGHT  = 0,
  parameter int unsigned P_START    = 0,
  parameter int          N_RD       = 1,
  parameter int          DEPTH      = 4,
  parameter int          DEPTH_LOG2 = 2,
  localparam int         W  = (LEFT >= RIGHT) ? (LEFT - RIGHT + 1) : (RIGHT - LEFT + 1),
  localparam int         A  = (ADDR_LEFT >= ADDR_RIGHT) ? (ADDR_LEFT - ADDR_RIGHT + 1) : (ADDR_RIGHT - ADDR_LEFT + 1),
  localparam int         CW = DEPTH_LOG2 + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       verinject__injector_state,
  input  logic [N_RD*W-1:0] unmodified,
  input  logic [N_RD*A-1:0] read_address,
  output logic [N_RD*W-1:0] modified,
  input  logic              do_write,
  input  logic [A-1:0]      write_address,
  output logic [CW-1:0]     fifo_count,
  output logic              fifo_overflow
`ifdef VERINJECT_MEM_STATS_EN
  ,
  output logic [31:0]       stat_pushes,
  output logic [31:0]       stat_invalidated
`endif
);

  localparam int          MEM_START = (MEM_LEFT <= MEM_RIGHT) ? MEM_LEFT : MEM_RIGHT;
  localparam int          MEM_LEN   = (MEM_LEFT <= MEM_RIGHT) ? (MEM_RIGHT - MEM_LEFT + 1) : (MEM_LEFT - MEM_RIGHT + 1);
  localparam logic [32:0] OWN_LO    = 33'(P_START);
  localparam logic [32:0] OWN_HI    = 33'(P_START) + 33'(MEM_LEN * W);
  localparam logic [31:0] IDX_EMPTY = 32'hFFFF_FFFF;
  localparam logic [31:0] CMD_CLEAR = 32'hFFFF_FFFE;

  // Word bit 0 of the flat bus corresponds to bit number min(LEFT,RIGHT) of the memory word.
  function automatic logic [31:0] word_base(input logic [A-1:0] addr);
    logic [31:0] rel;
    rel = 32'(addr) - 32'(MEM_START);
    return 32'(P_START) + rel * 32'(W);
  endfunction

  function automatic logic in_word(input logic [31:0] idx, input logic [31:0] ws);
    return ({1'b0, idx} >= {1'b0, ws}) && ({1'b0, idx} < ({1'b0, ws} + 33'(W)));
  endfunction

  function automatic logic is_owned(input logic [31:0] idx);
    return ({1'b0, idx} >= OWN_LO) && ({1'b0, idx} < OWN_HI);
  endfunction

  logic [31:0]           slot_q [DEPTH];
  logic [31:0]           slot_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] wptr_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic [31:0]           wws_s;
  logic                  clear_s;
  logic                  push_s;
  logic                  cmd_owned_s;
  logic [31:0]           rws_s;
  logic [31:0]           off_s;
  logic [W-1:0]          mask_s;
  logic                  hit_s;

  // Read path: per port, XOR every stored fault plus the live command falling in the addressed word.
  always_comb begin
    modified    = unmodified;
    rws_s       = 32'd0;
    off_s       = 32'd0;
    mask_s      = '0;
    hit_s       = 1'b0;
    cmd_owned_s = is_owned(verinject__injector_state) && (verinject__injector_state != CMD_CLEAR);
    for (int p = 0; p < N_RD; p++) begin
      rws_s  = word_base(read_address[p*A +: A]);
      mask_s = '0;
      for (int s = 0; s < DEPTH; s++) begin
        hit_s = (slot_q[s] != IDX_EMPTY) && in_word(slot_q[s], rws_s);
        off_s = slot_q[s] - rws_s;
        for (int b = 0; b < W; b++) begin
          mask_s[b] = mask_s[b] ^ (hit_s && (off_s == 32'(b)));
        end
      end
      hit_s = cmd_owned_s && in_word(verinject__injector_state, rws_s);
      off_s = verinject__injector_state - rws_s;
      for (int b = 0; b < W; b++) begin
        mask_s[b] = mask_s[b] ^ (hit_s && (off_s == 32'(b)));
      end
      modified[p*W +: W] = unmodified[p*W +: W] ^ mask_s;
    end
  end

  // Buffer next state: invalidate on write first, then clear or push the live command.
  always_comb begin
    slot_d  = slot_q;
    wptr_d  = wptr_q;
    ovf_d   = ovf_q;
    wws_s   = word_base(write_address);
    clear_s = (verinject__injector_state == CMD_CLEAR);
    push_s  = !clear_s && is_owned(verinject__injector_state);
    for (int s = 0; s < DEPTH; s++) begin
      if (do_write && (slot_q[s] != IDX_EMPTY) && in_word(slot_q[s], wws_s)) begin
        slot_d[s] = IDX_EMPTY;
      end else begin
        slot_d[s] = slot_q[s];
      end
    end
    if (clear_s) begin
      for (int s = 0; s < DEPTH; s++) begin
        slot_d[s] = IDX_EMPTY;
      end
      wptr_d = '0;
    end else if (push_s) begin
      ovf_d          = ovf_q | (slot_d[wptr_q] != IDX_EMPTY);
      slot_d[wptr_q] = verinject__injector_state;
      wptr_d         = wptr_q + DEPTH_LOG2'(1);
    end else begin
      wptr_d = wptr_q;
    end
  end

  // Occupancy: popcount of valid slots; slots are never compacted.
  always_comb begin
    fifo_count = '0;
    for (int s = 0; s < DEPTH; s++) begin
      fifo_count = fifo_count + CW'(slot_q[s] != IDX_EMPTY);
    end
  end

  // Buffer state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        slot_q[s] <= IDX_EMPTY;
      end
      wptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        slot_q[s] <= slot_d[s];
      end
      wptr_q <= wptr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign fifo_overflow = ovf_q;

`ifdef VERINJECT_MEM_STATS_EN
  logic [CW-1:0] inval_cnt_s;
  logic [31:0]   stat_pushes_q;
  logic [31:0]   stat_inval_q;

  // Number of valid slots emptied by this cycle's write.
  always_comb begin
    inval_cnt_s = '0;
    for (int s = 0; s < DEPTH; s++) begin
      inval_cnt_s = inval_cnt_s + CW'(do_write && (slot_q[s] != IDX_EMPTY) && in_word(slot_q[s], wws_s));
    end
  end

  // Wrapping statistics counters, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_pushes_q <= 32'd0;
      stat_inval_q  <= 32'd0;
    end else begin
      stat_pushes_q <= stat_pushes_q + 32'(push_s);
      stat_inval_q  <= stat_inval_q + 32'(inval_cnt_s);
    end
  end

  assign stat_pushes      = stat_pushes_q;
  assign stat_invalidated = stat_inval_q;
`endif

endmodule

// File: tb/tb_verinject_memn_injector.sv
// Self-checking bench for verinject_memn_injector: directed literal cases plus randomized traffic
// compared every cycle against a fault-list model using word/bit arithmetic.
module tb_verinject_memn_injector;

  localparam int W     = 8;
  localparam int NRD   = 2;
  localparam int A     = 4;
  localparam int DEPTH = 4;
  localparam int PS    = 100;
  localparam int NWORD = 16;
  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
  localparam logic [31:0] CLEAR = 32'hFFFF_FFFE;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      state;
  logic [NRD*W-1:0] unmod;
  logic [NRD*A-1:0] raddr;
  logic [NRD*W-1:0] modified;
  logic             do_write;
  logic [A-1:0]     waddr;
  logic [2:0]       fifo_count;
  logic             fifo_overflow;
`ifdef VERINJECT_MEM_STATS_EN
  logic [31:0]      stat_pushes;
  logic [31:0]      stat_inval;
`endif

  always #5 clock = ~clock;

  verinject_memn_injector #(
    .LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0), .MEM_LEFT(0), .MEM_RIGHT(15),
    .P_START(PS), .N_RD(NRD), .DEPTH(DEPTH), .DEPTH_LOG2(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .verinject__injector_state(state),
    .unmodified(unmod),
    .read_address(raddr),
    .modified(modified),
    .do_write(do_write),
    .write_address(waddr),
    .fifo_count(fifo_count),
    .fifo_overflow(fifo_overflow)
`ifdef VERINJECT_MEM_STATS_EN
    ,
    .stat_pushes(stat_pushes),
    .stat_invalidated(stat_inval)
`endif
  );

  // Model: the list of remembered faults held in their buffer positions.
  logic [31:0] m_slot [DEPTH];
  int          m_ptr;
  bit          m_ovf;
  logic [31:0] m_pushes;
  logic [31:0] m_inval;
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          checking = 1'b0;

  function automatic bit owned(input logic [31:0] v);
    return (v >= 32'(PS)) && (v < 32'(PS + NWORD * W));
  endfunction

  function automatic int word_of(input logic [31:0] v);
    return int'(v - 32'(PS)) / W;
  endfunction

  function automatic int bit_of(input logic [31:0] v);
    return int'(v - 32'(PS)) % W;
  endfunction

  function automatic logic [7:0] exp_mask(input int addr, input logic [31:0] live);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_slot[i] != EMPTY && word_of(m_slot[i]) == addr) m = m ^ (8'h01 << bit_of(m_slot[i]));
    end
    if (owned(live) && word_of(live) == addr) m = m ^ (8'h01 << bit_of(live));
    return m;
  endfunction

  function automatic int exp_count();
    int c;
    c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_slot[i] != EMPTY) c++;
    return c;
  endfunction

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_slot[i] = EMPTY;
      m_ptr = 0; m_ovf = 1'b0; m_pushes = 32'd0; m_inval = 32'd0;
    end else begin
      if (do_write) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m_slot[i] != EMPTY && word_of(m_slot[i]) == int'(waddr)) begin
            m_slot[i] = EMPTY;
            m_inval   = m_inval + 32'd1;
          end
        end
      end
      if (state == CLEAR) begin
        for (int i = 0; i < DEPTH; i++) m_slot[i] = EMPTY;
        m_ptr = 0;
      end else if (owned(state)) begin
        if (m_slot[m_ptr] != EMPTY) m_ovf = 1'b1;
        m_slot[m_ptr] = state;
        m_ptr    = (m_ptr + 1) % DEPTH;
        m_pushes = m_pushes + 32'd1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #2;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (checking) begin
      #1;
      chk("fifo_count", 32'(fifo_count), 32'(exp_count()));
      chk("fifo_overflow", 32'(fifo_overflow), 32'(m_ovf));
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("modified_p%0d", p), 32'(modified[p*W +: W]),
            32'(unmod[p*W +: W] ^ exp_mask(int'(raddr[p*A +: A]), state)));
      end
`ifdef VERINJECT_MEM_STATS_EN
      chk("stat_pushes", stat_pushes, m_pushes);
      chk("stat_invalidated", stat_inval, m_inval);
`endif
    end
  end

  initial begin
    int r;
    reset = 1'b1; state = EMPTY; unmod = '0; raddr = '0; do_write = 1'b0; waddr = '0;
    tick();
    checking = 1'b1;
    tick();
    reset = 1'b0; unmod = 16'h5AA5;
    at_neg();
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(fifo_overflow), 32'd0);
    chk("rst_passthru", 32'(modified), 32'h5AA5);
    tick();

    state = 32'd117; raddr = {4'd0, 4'd2}; unmod = 16'h0000;
    at_neg();
    chk("inj_same_cycle", 32'(modified[7:0]), 32'h02);
    tick();
    state = EMPTY;
    at_neg();
    chk("inj_stored", 32'(modified[7:0]), 32'h02);
    chk("inj_count", 32'(fifo_count), 32'd1);

    raddr = {4'd2, 4'd3}; unmod = {8'hFF, 8'h3C};
    at_neg();
    chk("port1_hit", 32'(modified[15:8]), 32'hFD);
    chk("port0_miss", 32'(modified[7:0]), 32'h3C);
    tick();

    do_write = 1'b1; waddr = 4'd2;
    tick();
    do_write = 1'b0; raddr = {4'd0, 4'd2}; unmod = 16'h0000;
    at_neg();
    chk("inval_count", 32'(fifo_count), 32'd0);
    chk("inval_read", 32'(modified[7:0]), 32'h00);
    tick();
    state = 32'd117;
    tick();
    state = 32'd118; do_write = 1'b1; waddr = 4'd2;
    tick();
    state = EMPTY; do_write = 1'b0;
    at_neg();
    chk("inval_push_count", 32'(fifo_count), 32'd1);
    chk("inval_push_read", 32'(modified[7:0]), 32'h04);
    state = CLEAR;
    tick();

    for (int i = 100; i <= 104; i++) begin
      state = 32'(i);
      tick();
    end
    state = EMPTY; raddr = '0; unmod = '0;
    at_neg();
    chk("ovf_mask", 32'(modified[7:0]), 32'h1E);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(fifo_overflow), 32'd1);
    state = CLEAR;
    tick();
    state = EMPTY;
    at_neg();
    chk("clear_count", 32'(fifo_count), 32'd0);
    chk("clear_keeps_ovf", 32'(fifo_overflow), 32'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    state = 32'd130; tick();
    state = 32'd131; tick();
    state = 32'd200; tick();
    state = CLEAR; tick();
    state = EMPTY;
    at_neg();
    chk("clear3_count", 32'(fifo_count), 32'd0);
    chk("clear3_ovf", 32'(fifo_overflow), 32'd0);
`ifdef VERINJECT_MEM_STATS_EN
    chk("clear3_pushes", stat_pushes, 32'd3);
`endif

    state = 32'd120; tick();
    state = 32'd121; reset = 1'b1; tick();
    reset = 1'b0; state = EMPTY; raddr = {4'd2, 4'd2}; unmod = 16'h0000;
    at_neg();
    chk("midreset_mask", 32'(modified), 32'h0000);
    chk("midreset_count", 32'(fifo_count), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 45)      state = 32'(PS) + $urandom_range(0, NWORD * W - 1);
      else if (r < 50) state = CLEAR;
      else if (r < 55) state = $urandom_range(0, PS - 1);
      else if (r < 60) state = 32'(PS + NWORD * W) + $urandom_range(0, 1000);
      else if (r < 62) state = $urandom;
      else             state = EMPTY;
      do_write = ($urandom_range(0, 3) == 0);
      waddr    = 4'($urandom_range(0, NWORD - 1));
      raddr    = 8'($urandom);
      unmod    = 16'($urandom);
      tick();
    end

    at_neg();
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
